// File: rtl/rf_write_arbiter_if.sv
// Request-side bundle of the register-file write arbiter: pipeline writeback
// and debug/loader handshakes.
interface rf_write_arbiter_if #(
    parameter int ADW = 5,
    parameter int DPW = 32
);
    logic           wb_valid;
    logic [ADW-1:0] wb_addr;
    logic [DPW-1:0] wb_data;
    logic           wb_ready;
    logic           dbg_valid;
    logic [ADW-1:0] dbg_addr;
    logic [DPW-1:0] dbg_data;
    logic           dbg_ready;

    modport master (
        output wb_valid, wb_addr, wb_data, dbg_valid, dbg_addr, dbg_data,
        input  wb_ready, dbg_ready
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, dbg_valid, dbg_addr, dbg_data,
        output wb_ready, dbg_ready
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between writeback and a FIFO-buffered
// debug requester. Optional statistics counters under RFARB_STATS_EN.
module rf_write_arbiter #(
    parameter int ADW        = 5,
    parameter int DPW        = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    rf_write_arbiter_if.slave             bus,
    output logic                          we,
    output logic [ADW-1:0]                addr_3,
    output logic [DPW-1:0]                wd_3,
    output logic                          dbg_pending,
    output logic [$clog2(FIFO_DEPTH):0]   dbg_count
`ifdef RFARB_STATS_EN
    ,
    output logic [15:0]                   stat_force_cnt,
    output logic [15:0]                   stat_x0_drop_cnt
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {ST_ARB, ST_FORCE} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t         state, state_nxt;
    logic [SW-1:0]  starve, starve_nxt;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [ADW-1:0] mem_addr [FIFO_DEPTH];
    logic [DPW-1:0] mem_data [FIFO_DEPTH];
    logic           empty, full, push, pop;
    logic           grant_wb_p0, grant_dbg_p0, grant_p0;
    logic [ADW-1:0] addr_p0;
    logic [DPW-1:0] data_p0;

    assign empty         = (count == '0);
    assign full          = (count == CW'(FIFO_DEPTH));
    assign bus.dbg_ready = !full;
    assign dbg_pending   = !empty;
    assign dbg_count     = count;
    assign push          = bus.dbg_valid && !full;
    assign pop           = grant_dbg_p0;

    always_comb begin
        state_nxt    = state;
        starve_nxt   = starve;
        bus.wb_ready = 1'b0;
        grant_wb_p0  = 1'b0;
        grant_dbg_p0 = 1'b0;
        case (state)
            ST_ARB: begin
                bus.wb_ready = 1'b1;
                if (bus.wb_valid) begin
                    grant_wb_p0 = 1'b1;
                    if (!empty) begin
                        starve_nxt = starve + SW'(1);
                        if (starve == SW'(STARVE_MAX - 1))
                            state_nxt = ST_FORCE;
                    end
                end else if (!empty) begin
                    grant_dbg_p0 = 1'b1;
                    starve_nxt   = '0;
                end else begin
                    starve_nxt = '0;
                end
            end
            ST_FORCE: begin
                // Writeback is stalled for this one slot so the debug head drains.
                grant_dbg_p0 = !empty;
                starve_nxt   = '0;
                state_nxt    = ST_ARB;
            end
            default: state_nxt = ST_ARB;
        endcase
    end

    assign grant_p0 = grant_wb_p0 || grant_dbg_p0;
    assign addr_p0  = grant_wb_p0 ? bus.wb_addr : mem_addr[rd_ptr];
    assign data_p0  = grant_wb_p0 ? bus.wb_data : mem_data[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_ARB;
            starve <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state  <= state_nxt;
            starve <= starve_nxt;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= bus.dbg_addr;
            mem_data[wr_ptr] <= bus.dbg_data;
        end
    end

    // ---- grant stage -> registered write port ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we     <= 1'b0;
            addr_3 <= '0;
            wd_3   <= '0;
        end else begin
            // x0 is architecturally zero: consume the request but suppress the write.
            we <= grant_p0 && (addr_p0 != '0);
            if (grant_p0) begin
                addr_3 <= addr_p0;
                wd_3   <= data_p0;
            end
        end
    end

`ifdef RFARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_force_cnt   <= '0;
            stat_x0_drop_cnt <= '0;
        end else begin
            if (state == ST_FORCE)
                stat_force_cnt <= sat_inc(stat_force_cnt);
            if (grant_p0 && (addr_p0 == '0))
                stat_x0_drop_cnt <= sat_inc(stat_x0_drop_cnt);
        end
    end
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: directed stimulus queues expected
// register-file writes; a negedge monitor pops and compares them.
module tb_rf_write_arbiter;
    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  addr_3;
    logic [31:0] wd_3;
    logic        dbg_pending;
    logic [2:0]  dbg_count;
`ifdef RFARB_STATS_EN
    logic [15:0] stat_force_cnt;
    logic [15:0] stat_x0_drop_cnt;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    rf_write_arbiter_if #(.ADW(5), .DPW(32)) bus ();

    rf_write_arbiter #(.ADW(5), .DPW(32), .FIFO_DEPTH(4), .STARVE_MAX(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .we          (we),
        .addr_3      (addr_3),
        .wd_3        (wd_3),
        .dbg_pending (dbg_pending),
        .dbg_count   (dbg_count)
`ifdef RFARB_STATS_EN
        ,
        .stat_force_cnt   (stat_force_cnt),
        .stat_x0_drop_cnt (stat_x0_drop_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back('{a: a, d: d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every observed register-file write must match the queue head.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && we) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", addr_3, wd_3);
            end else begin
                e = exp_q.pop_front();
                if (addr_3 !== e.a || wd_3 !== e.d) begin
                    fails++;
                    $display("FAIL write_order: got addr=%0d data=%h, required addr=%0d data=%h",
                             addr_3, wd_3, e.a, e.d);
                end
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        bus.dbg_valid = 1'b0;
        bus.dbg_addr  = '0;
        bus.dbg_data  = '0;

        // Reset state
        #2;
        check("rst_we",          32'(we),          32'd0);
        check("rst_addr_3",      32'(addr_3),      32'd0);
        check("rst_wd_3",        wd_3,             32'd0);
        check("rst_dbg_count",   32'(dbg_count),   32'd0);
        check("rst_dbg_pending", 32'(dbg_pending), 32'd0);
        check("rst_dbg_ready",   32'(bus.dbg_ready), 32'd1);
        check("rst_wb_ready",    32'(bus.wb_ready),  32'd1);
        #10 rst_n = 1'b1;
        tick();

        // Debug preload with no writeback
        bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd5; bus.dbg_data = 32'hDEADBEEF;
        expect_wr(5'd5, 32'hDEADBEEF);
        tick();
        bus.dbg_addr = 5'd6; bus.dbg_data = 32'h12345678;
        expect_wr(5'd6, 32'h12345678);
        tick();
        bus.dbg_valid = 1'b0;
        check("preload_first_write_addr", 32'(addr_3), 32'd5);
        check("preload_count_mid", 32'(dbg_count), 32'd1);
        tick();
        check("preload_count_end", 32'(dbg_count), 32'd0);
        tick();

        // Starvation: writeback held, one debug entry waiting
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd10; bus.wb_data = 32'd100;
        bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd7; bus.dbg_data = 32'h77;
        expect_wr(5'd10, 32'd100);
        tick();
        bus.dbg_valid = 1'b0;
        check("starve_count_one", 32'(dbg_count), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("starve_wb_ready_%0d", i), 32'(bus.wb_ready), 32'd1);
            bus.wb_data = 32'd101 + 32'(i);
            expect_wr(5'd10, 32'd101 + 32'(i));
            tick();
        end
        check("force_wb_ready", 32'(bus.wb_ready), 32'd0);
        bus.wb_data = 32'd200;
        expect_wr(5'd7, 32'h77);
        tick();
        check("after_force_wb_ready", 32'(bus.wb_ready), 32'd1);
        check("after_force_count", 32'(dbg_count), 32'd0);
        expect_wr(5'd10, 32'd200);
        tick();
        bus.wb_valid = 1'b0;
        tick();

        // FIFO full: five pushes under continuous writeback
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd11;
        bus.dbg_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("full_dbg_ready_%0d", i), 32'(bus.dbg_ready), (i < 4) ? 32'd1 : 32'd0);
            bus.dbg_addr = 5'd20 + 5'(i);
            bus.dbg_data = 32'(i);
            bus.wb_data  = 32'h1100 + 32'(i);
            expect_wr(5'd11, 32'h1100 + 32'(i));
            tick();
        end
        bus.dbg_valid = 1'b0;
        bus.wb_valid  = 1'b0;
        check("full_count", 32'(dbg_count), 32'd4);
        check("full_dbg_ready", 32'(bus.dbg_ready), 32'd0);
        for (int i = 0; i < 4; i++) expect_wr(5'd20 + 5'(i), 32'(i));
        repeat (5) tick();
        check("full_drained", 32'(dbg_count), 32'd0);

        // x0 drop from both sources
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFFFFFF;
        tick();
        bus.wb_valid = 1'b0;
        check("x0_wb_we", 32'(we), 32'd0);
        check("x0_wb_wd_3", wd_3, 32'hFFFFFFFF);
        bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd0; bus.dbg_data = 32'h0000ABCD;
        tick();
        bus.dbg_valid = 1'b0;
        check("x0_dbg_queued", 32'(dbg_count), 32'd1);
        tick();
        check("x0_dbg_we", 32'(we), 32'd0);
        check("x0_dbg_wd_3", wd_3, 32'h0000ABCD);
        check("x0_dbg_popped", 32'(dbg_count), 32'd0);
`ifdef RFARB_STATS_EN
        check("stat_x0_drop_cnt", 32'(stat_x0_drop_cnt), 32'd2);
        check("stat_force_cnt",   32'(stat_force_cnt),   32'd1);
`endif
        tick();

        // Simultaneous push and pop at occupancy 2
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd13; bus.wb_data = 32'h500;
        bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd12; bus.dbg_data = 32'hC1;
        expect_wr(5'd13, 32'h500);
        tick();
        bus.wb_data = 32'h501;
        bus.dbg_addr = 5'd14; bus.dbg_data = 32'hC2;
        expect_wr(5'd13, 32'h501);
        tick();
        bus.wb_valid = 1'b0;
        bus.dbg_addr = 5'd15; bus.dbg_data = 32'hC3;
        check("pushpop_count_before", 32'(dbg_count), 32'd2);
        expect_wr(5'd12, 32'hC1);
        expect_wr(5'd14, 32'hC2);
        expect_wr(5'd15, 32'hC3);
        tick();
        bus.dbg_valid = 1'b0;
        check("pushpop_count_after", 32'(dbg_count), 32'd2);
        repeat (3) tick();
        check("pushpop_drained", 32'(dbg_count), 32'd0);

        // Reset mid-operation with three queued entries
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd2;
        bus.dbg_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.dbg_addr = 5'd16 + 5'(i);
            bus.dbg_data = 32'h16 + 32'(i);
            bus.wb_data  = 32'h600 + 32'(i);
            expect_wr(5'd2, 32'h600 + 32'(i));
            tick();
        end
        bus.wb_valid  = 1'b0;
        bus.dbg_valid = 1'b0;
        check("reset_mid_count_before", 32'(dbg_count), 32'd3);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("reset_mid_we", 32'(we), 32'd0);
        check("reset_mid_count", 32'(dbg_count), 32'd0);
        check("reset_mid_pending", 32'(dbg_pending), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (8) tick();
        check("reset_mid_no_late_write", 32'(we), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
